// File: rtl/uart_rx_ctrl.sv
// UART receiver frame controller: start-bit detect, edge/bit counting, LSB-first
// deserialisation, parity and stop checking, one-cycle valid strobe.
`timescale 1ns/1ps
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sample_bit,
    output logic                  data_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  samp_en_q, samp_en_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  bit_end_c;
    logic [PRESCALE_W-1:0] presc_legal_c;

    // Unsupported oversampling ratios fall back to 8
    always_comb begin
        presc_legal_c = PRESCALE_W'(8);
        if (prescale == PRESCALE_W'(16) || prescale == PRESCALE_W'(32)) begin
            presc_legal_c = prescale;
        end
    end

    assign bit_end_c = (edge_q == presc_q - PRESCALE_W'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            presc_q   <= PRESCALE_W'(8);
            edge_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            samp_en_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            samp_en_q <= samp_en_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;

        if (state_q != ST_IDLE) begin
            edge_d = bit_end_c ? '0 : edge_q + PRESCALE_W'(1);
            if (bit_end_c) begin
                bit_d = bit_q + BIT_CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_d   = ST_START;
                    presc_d   = presc_legal_c;
                    edge_d    = '0;
                    bit_d     = '0;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    if (sample_bit) begin
                        state_d = ST_IDLE;
                        bit_d   = '0;
                    end else begin
                        state_d   = ST_DATA;
                        par_en_d  = PAR_EN;
                        par_typ_d = PAR_TYP;
                    end
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    data_d = {sample_bit, data_q[DATA_WIDTH-1:1]};
                    if (bit_q == BIT_CNT_W'(DATA_WIDTH)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end_c) begin
                    par_err_d = (sample_bit != ((^data_q) ^ par_typ_q));
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    stp_err_d = ~sample_bit;
                    valid_d   = sample_bit & ~par_err_q;
                    // Line already low at stop end: next frame starts without idle
                    if (!RX_IN) begin
                        state_d   = ST_START;
                        presc_d   = presc_legal_c;
                        bit_d     = '0;
                        par_err_d = 1'b0;
                        stp_err_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        bit_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        samp_en_d = (state_d != ST_IDLE);
    end

    assign data_samp_en = samp_en_q;
    assign edge_cnt     = edge_q;
    assign bit_cnt      = bit_q;
    assign P_DATA       = data_q;
    assign data_valid   = valid_q;
    assign par_err      = par_err_q;
    assign stp_err      = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames, expected bytes and strobe cycles queued.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          sample_bit;
    logic          data_samp_en;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sample_bit(sample_bit),
        .data_samp_en(data_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Sampler model: takes the line mid-bit and holds it until the next mid-bit
    int   bit_p = 8;
    logic samp_q;
    always @(posedge CLK or negedge RST) begin
        if (!RST) samp_q <= 1'b1;
        else if (data_samp_en && edge_cnt == PW'(bit_p / 2)) samp_q <= RX_IN;
    end
    assign sample_bit = samp_q;

    typedef struct {
        logic [7:0] data;
        int         at_cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued frame
    always @(negedge CLK) begin
        exp_t e;
        if (RST && data_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: actual P_DATA=%0h expected no strobe", P_DATA);
            end else begin
                e = exp_q.pop_front();
                check("p_data", 32'(P_DATA), 32'(e.data));
                check("valid_cycle", 32'(cyc), 32'(e.at_cyc));
                check("flags_on_valid", 32'({par_err, stp_err}), 32'(0));
            end
        end
    end

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (bit_p) @(negedge CLK);
    endtask

    // Called on a negedge; strobe expected one cycle after the stop bit's last edge
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop, input logic expect_valid);
        int t0;
        int len;
        exp_t e;
        t0  = cyc;
        len = (pen ? 11 : 10) * bit_p;
        if (expect_valid) begin
            e.data   = d;
            e.at_cyc = t0 + len + 1;
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic idle_wait(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_p_data"}, 32'(P_DATA), 32'(0));
        check({tag, "_valid"}, 32'(data_valid), 32'(0));
        check({tag, "_flags"}, 32'({par_err, stp_err}), 32'(0));
        check({tag, "_edge_cnt"}, 32'(edge_cnt), 32'(0));
        check({tag, "_bit_cnt"}, 32'(bit_cnt), 32'(0));
        check({tag, "_samp_en"}, 32'(data_samp_en), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // prescale 8, no parity, 0xA5: strobe 81 cycles after the falling edge
        bit_p = 8; prescale = PW'(8); PAR_EN = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_wait(4);
        check("a5_flags", 32'({par_err, stp_err}), 32'(0));

        // prescale 16, even parity, 0x3C: good parity then bad parity
        bit_p = 16; prescale = PW'(16); PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        idle_wait(4);
        check("3c_good_par_err", 32'(par_err), 32'(0));
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_wait(4);
        check("3c_bad_par_err", 32'(par_err), 32'(1));
        check("3c_bad_stp_err", 32'(stp_err), 32'(0));
        check("3c_bad_p_data", 32'(P_DATA), 32'(8'h3C));

        // prescale 32, odd parity, 0x01 with parity 0 and a low stop bit
        bit_p = 32; prescale = PW'(32); PAR_EN = 1'b1; PAR_TYP = 1'b1;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_wait(4);
        check("stop_low_stp_err", 32'(stp_err), 32'(1));
        check("stop_low_par_err", 32'(par_err), 32'(0));
        check("stop_low_p_data", 32'(P_DATA), 32'(8'h01));

        // Start-bit glitch at prescale 16
        bit_p = 16; prescale = PW'(16); PAR_EN = 1'b0;
        RX_IN = 1'b0;
        @(negedge CLK);
        check("glitch_samp_en_on", 32'(data_samp_en), 32'(1));
        @(negedge CLK);
        RX_IN = 1'b1;
        repeat (20) @(negedge CLK);
        check("glitch_samp_en_off", 32'(data_samp_en), 32'(0));
        check("glitch_flags", 32'({par_err, stp_err}), 32'(0));
        check("glitch_edge_cnt", 32'(edge_cnt), 32'(0));
        check("glitch_p_data", 32'(P_DATA), 32'(8'h01));

        // Back-to-back frames at prescale 8: strobes 80 cycles apart
        bit_p = 8; prescale = PW'(8); PAR_EN = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_wait(4);

        // Unsupported prescale 12 runs as 8
        prescale = PW'(12);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_wait(4);

        // Reset in the middle of data bit 4, then a clean 0x81 frame
        prescale = PW'(8);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        check("mid_bit_cnt", 32'(bit_cnt), 32'(5));
        RST = 1'b0;
        #1;
        check_all_zero("mid_reset");
        idle_wait(2);
        RST = 1'b1;
        idle_wait(3);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_wait(6);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_valid: actual=%0d strobes outstanding expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Frame controller for the UART receiver. Detects the start bit, runs the per-bit edge counter and bit counter, and enables the oversampling data sampler. Consumes the sampler's majority-voted bit to deserialize data, check parity and check the stop bit. Presents a parallel byte with a one-cycle valid strobe and error flags to the system side.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, LSB first
PRESCALE_W, 6, width of prescale and edge counter (supports prescale up to 32)

Ports:
CLK  input  1  receiver oversampling clock
RST  input  1  asynchronous active-low reset
RX_IN  input  1  UART serial line, idle high
prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = frame contains a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
sample_bit  input  1  majority-voted bit from the data sampler
data_samp_en  output  1  enables the data sampler
edge_cnt  output  PRESCALE_W  current oversampling edge within the bit, 0..prescale-1
bit_cnt  output  4  index of the current bit within the frame
P_DATA  output  DATA_WIDTH  received byte
data_valid  output  1  one-cycle strobe: P_DATA holds a good frame
par_err  output  1  parity error flag for the last frame
stp_err  output  1  stop-bit error flag for the last frame

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; edge_cnt, bit_cnt, P_DATA, data_valid, par_err, stp_err, data_samp_en all 0. Reset mid-frame discards the frame with no valid strobe.
- Prescale latching: prescale is latched on IDLE->START. Any value other than 8, 16 or 32 is latched as 8.
- Bit end: "bit end" means edge_cnt == latched_prescale-1.
- Counters: edge_cnt increments every CLK outside IDLE and wraps to 0 at bit end. bit_cnt increments at each bit end and is cleared on entry to START.
- data_samp_en: 1 in every state except IDLE (registered and aligned with the state).
- Bit capture: sample_bit is captured at bit end. The sampler output is stable by then for all legal prescales.
- States:
  - IDLE: RX_IN==0 -> START; clear edge_cnt, bit_cnt, par_err, stp_err.
  - START: at bit end, sample_bit==1 (glitch) -> IDLE with no flags set; sample_bit==0 -> DATA.
  - DATA: at each bit end, shift sample_bit into P_DATA MSB side (LSB first on the line). After DATA_WIDTH bits -> PARITY if PAR_EN, else STOP.
  - PARITY: at bit end, expected = ^P_DATA XOR PAR_TYP. par_err <= (sample_bit != expected). -> STOP.
  - STOP: at bit end, stp_err <= (sample_bit==0). data_valid=1 for exactly one cycle (the cycle after bit end) only if stp_err and par_err are both 0. Next state: RX_IN==0 -> START (back-to-back frame, counters cleared, error flags cleared); otherwise -> IDLE.
- P_DATA holds its value until the next frame's first data bit shifts in. Error flags hold until the next start-bit detect.
- PAR_EN and PAR_TYP are sampled at START bit end and held for the frame. Changes mid-frame are ignored.
- Latency: data_valid asserts 1 CLK after the stop-bit's final edge; frame length = (10 + PAR_EN) × prescale cycles from the falling edge.

Test Plan:
- prescale=8, PAR_EN=0, send 0xA5 with stop=1 -> P_DATA=0xA5, data_valid high for one CLK at cycle 81 after falling edge, par_err=stp_err=0.
- prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> data_valid, par_err=0. Repeat with parity bit 1 -> par_err=1, no data_valid.
- prescale=32, PAR_EN=1, PAR_TYP=1, send 0x01 with parity 0, stop=0 -> stp_err=1, par_err=0, no data_valid.
- RX_IN low for 2 edges then high (prescale=16) -> START rejects at bit end and returns to IDLE; no flags, no valid; data_samp_en drops.
- Two back-to-back frames 0x55 then 0xFF with no idle gap (prescale=8) -> two data_valid strobes exactly 80 CLK apart with correct P_DATA.
- RST pulsed low during DATA bit 4 -> all outputs 0 immediately. The next clean frame 0x81 is received correctly.
